// File: rtl/binary_scan_ctrl.sv
// Column-scan scheduler for the binary-clock LED array: blanking, PWM
// brightness and a frame-synchronous double-buffered time load.
module binary_scan_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int PWM_BITS     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                time_valid,
    output logic                time_ready,
    input  logic [1:0]          h1,
    input  logic [3:0]          h0,
    input  logic [2:0]          m1,
    input  logic [3:0]          m0,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [3:0]          row,
    output logic [3:0]          col,
    output logic                frame_start
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic {BLANK, DWELL} state_t;

    state_t              state_q, state_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [12:0]         disp_q, disp_d;
    logic [12:0]         pend_q, pend_d;
    logic                full_q, full_d;
    logic                run_q, run_d;
    logic                ready_q, ready_d;
    logic [3:0]          row_q, row_d;
    logic [3:0]          col_q, col_d;
    logic                fs_q, fs_d;
    logic [3:0]          digit;
    logic                pwm_on;

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        run_d     = 1'b1;
        // The cycle after reset release replays the first blank of column 3.
        if (!run_q) begin
            state_d   = BLANK;
            col_idx_d = 2'd3;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                        state_d = DWELL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DWELL: begin
                    if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                        state_d   = BLANK;
                        cnt_d     = '0;
                        col_idx_d = col_idx_q - 2'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end

        if (state_q == DWELL && state_d == DWELL) begin
            pwm_d = pwm_q + PWM_BITS'(1);
        end else begin
            pwm_d = '0;
        end

        fs_d = (state_d == BLANK) && (cnt_d == '0) && (col_idx_d == 2'd3);

        bright_d = bright_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        full_d   = full_q;
        // Swap needs full, capture needs empty, so they never collide.
        if (fs_d) begin
            bright_d = brightness;
            if (full_q) begin
                disp_d = pend_q;
                full_d = 1'b0;
            end
        end
        if (time_valid && ready_q) begin
            pend_d = {h1, h0, m1, m0};
            full_d = 1'b1;
        end
        ready_d = !full_d;

        unique case (col_idx_d)
            2'd3:    digit = {2'b00, disp_q[12:11]};
            2'd2:    digit = disp_q[10:7];
            2'd1:    digit = {1'b0, disp_q[6:4]};
            default: digit = disp_q[3:0];
        endcase

        pwm_on = (&bright_d) || (pwm_d < bright_d);

        row_d = '0;
        col_d = '0;
        if (state_d == DWELL) begin
            col_d = 4'b0001 << col_idx_d;
            if (pwm_on) begin
                row_d = digit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            col_idx_q <= 2'd3;
            cnt_q     <= '0;
            pwm_q     <= '0;
            bright_q  <= '0;
            disp_q    <= '0;
            pend_q    <= '0;
            full_q    <= 1'b0;
            run_q     <= 1'b0;
            ready_q   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            pwm_q     <= pwm_d;
            bright_q  <= bright_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            full_q    <= full_d;
            run_q     <= run_d;
            ready_q   <= ready_d;
            row_q     <= row_d;
            col_q     <= col_d;
            fs_q      <= fs_d;
        end
    end

    assign time_ready  = ready_q;
    assign row         = row_q;
    assign col         = col_q;
    assign frame_start = fs_q;

endmodule
